// File: rtl/instruction_memory_loader_pkg.sv
// Shared processor package: loader state encoding, the default fetch NOP,
// the RV32I base opcode constants and a helper mapping write states to byte
// lanes.
package instruction_memory_loader_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_WORD = 3'd1,
    WR_B0     = 3'd2,
    WR_B1     = 3'd3,
    WR_B2     = 3'd4,
    WR_B3     = 3'd5,
    DONE      = 3'd6
  } loader_state_t;

  // addi x0,x0,0
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h00000013;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  function automatic logic [1:0] wr_lane(input loader_state_t s);
    logic [1:0] lane;
    lane = 2'd0;
    case (s)
      WR_B1:   lane = 2'd1;
      WR_B2:   lane = 2'd2;
      WR_B3:   lane = 2'd3;
      default: lane = 2'd0;
    endcase
    return lane;
  endfunction

  function automatic logic is_write_state(input loader_state_t s);
    return (s == WR_B0) || (s == WR_B1) || (s == WR_B2) || (s == WR_B3);
  endfunction

endpackage

// File: rtl/instruction_memory_loader_byte_mem.sv
// byte_mem: byte-addressed storage with one synchronous byte write port and
// one combinational little-endian 32-bit read port.  All indices wrap modulo
// MEM_BYTES.  Contents are never reset.
//   clk     : clock
//   i_we    : byte write enable
//   i_waddr : byte write address
//   i_wdata : byte write data
//   i_raddr : read byte address (first, least-significant byte)
//   o_rdata : {mem[a+3], mem[a+2], mem[a+1], mem[a]}
module byte_mem #(
  parameter int MEM_BYTES = 256
) (
  input  logic                         clk,
  input  logic                         i_we,
  input  logic [$clog2(MEM_BYTES)-1:0] i_waddr,
  input  logic [7:0]                   i_wdata,
  input  logic [$clog2(MEM_BYTES)-1:0] i_raddr,
  output logic [31:0]                  o_rdata
);

  localparam int AW = $clog2(MEM_BYTES);

  logic [7:0]    r_mem [MEM_BYTES];
  logic [AW-1:0] w_a1;
  logic [AW-1:0] w_a2;
  logic [AW-1:0] w_a3;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // AW-bit adds give the modulo-MEM_BYTES wrap for fetches near the top.
  assign w_a1 = i_raddr + AW'(1);
  assign w_a2 = i_raddr + AW'(2);
  assign w_a3 = i_raddr + AW'(3);

  assign o_rdata = {r_mem[w_a3], r_mem[w_a2], r_mem[w_a1], r_mem[i_raddr]};

endmodule

// File: rtl/instruction_memory_loader.sv
// instruction_memory_loader: streams 32-bit instruction words into a byte
// memory one byte per cycle and serves combinational instruction fetches.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | after reset, no load in progress
//   WAIT_WORD | load_ready=1, waiting for a load_valid handshake
//   WR_B0..B3 | writing byte k of the held word to mem[wptr+k]
//   DONE      | load finished (last seen or memory full), result held
//
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   load_start               : begin a new load at byte 0 (IDLE/DONE only)
//   load_valid/word/last     : word stream; transfer when valid && ready
//   load_ready               : loader accepts a word this cycle
//   busy                     : load in progress
//   load_done, overflow      : completion status, held until restart/reset
//   load_count               : complete words written in this load
//   Inst_Address/Instruction : fetch port; NOP_WORD while busy
module instruction_memory_loader
  import instruction_memory_loader_pkg::*;
#(
  parameter int          MEM_BYTES = 256,
  parameter logic [31:0] NOP_WORD  = NOP_WORD_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load_start,
  input  logic                           load_valid,
  input  logic [31:0]                    load_word,
  input  logic                           load_last,
  output logic                           load_ready,
  output logic                           busy,
  output logic                           load_done,
  output logic                           overflow,
  output logic [$clog2(MEM_BYTES/4):0]   load_count,
  input  logic [63:0]                    Inst_Address,
  output logic [31:0]                    Instruction
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int CW = $clog2(MEM_BYTES / 4) + 1;
  localparam logic [AW-1:0] LAST_WPTR = AW'(MEM_BYTES - 4);

  loader_state_t r_state;
  loader_state_t w_state_nxt;

  logic [AW-1:0] r_wptr;
  logic [CW-1:0] r_count;
  logic          r_done;
  logic          r_overflow;
  logic [31:0]   r_word;
  logic          r_last;

  logic          w_we;
  logic [1:0]    w_lane;
  logic [AW-1:0] w_waddr;
  logic [7:0]    w_wdata;
  logic [31:0]   w_rdata;
  logic          w_unused_addr_hi;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (load_start) w_state_nxt = WAIT_WORD;
      WAIT_WORD:  if (load_valid) w_state_nxt = WR_B0;
      WR_B0:      w_state_nxt = WR_B1;
      WR_B1:      w_state_nxt = WR_B2;
      WR_B2:      w_state_nxt = WR_B3;
      WR_B3:      w_state_nxt = (r_last || (r_wptr == LAST_WPTR)) ? DONE : WAIT_WORD;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_count    <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_word     <= '0;
      r_last     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (load_start) begin
            r_wptr     <= '0;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
          end
        end
        WAIT_WORD: begin
          if (load_valid) begin
            r_word <= load_word;
            r_last <= load_last;
          end
        end
        WR_B3: begin
          r_wptr  <= r_wptr + AW'(4);
          r_count <= r_count + CW'(1);
          if (r_last) begin
            r_done <= 1'b1;
          end else if (r_wptr == LAST_WPTR) begin
            r_done     <= 1'b1;
            r_overflow <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Reset suppresses the in-flight byte so an aborted load stops exactly at
  // the byte it was on; earlier bytes stay in memory.
  assign w_lane  = wr_lane(r_state);
  assign w_we    = !reset && is_write_state(r_state);
  assign w_waddr = r_wptr + AW'(w_lane);
  assign w_wdata = r_word[8*w_lane +: 8];

  byte_mem #(
    .MEM_BYTES (MEM_BYTES)
  ) u_byte_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (Inst_Address[AW-1:0]),
    .o_rdata (w_rdata)
  );

  // Upper address bits only select aliases of the same bytes.
  assign w_unused_addr_hi = ^Inst_Address[63:AW];

  assign load_ready  = (r_state == WAIT_WORD);
  assign busy        = (r_state != IDLE) && (r_state != DONE);
  assign load_done   = r_done;
  assign overflow    = r_overflow;
  assign load_count  = r_count;
  assign Instruction = busy ? NOP_WORD : w_rdata;

endmodule

// File: tb/tb_instruction_memory_loader.sv
module tb_instruction_memory_loader;

  localparam int MB = 16;
  localparam int CW = $clog2(MB / 4) + 1;
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_start = 1'b0;
  logic          load_valid = 1'b0;
  logic [31:0]   load_word = '0;
  logic          load_last = 1'b0;
  logic          load_ready;
  logic          busy;
  logic          load_done;
  logic          overflow;
  logic [CW-1:0] load_count;
  logic [63:0]   inst_addr = '0;
  logic [31:0]   instruction;

  int n_checks = 0;
  int n_errors = 0;

  // Reference memory: bytes the bench knows were written, and the byte
  // offset where the next loaded word is expected to land.
  logic [7:0] m_mem   [MB];
  bit         m_known [MB];
  int         m_wptr = 0;

  instruction_memory_loader #(.MEM_BYTES(MB)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .load_valid   (load_valid),
    .load_word    (load_word),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .busy         (busy),
    .load_done    (load_done),
    .overflow     (overflow),
    .load_count   (load_count),
    .Inst_Address (inst_addr),
    .Instruction  (instruction)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] m_fetch(input logic [63:0] addr);
    int a;
    a = int'(addr % 64'(MB));
    return {m_mem[(a+3)%MB], m_mem[(a+2)%MB], m_mem[(a+1)%MB], m_mem[a]};
  endfunction

  function automatic bit m_fetch_known(input logic [63:0] addr);
    int a;
    a = int'(addr % 64'(MB));
    return m_known[a] && m_known[(a+1)%MB] && m_known[(a+2)%MB] && m_known[(a+3)%MB];
  endfunction

  function automatic void m_put_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      m_mem[(m_wptr+k)%MB]   = w[8*k +: 8];
      m_known[(m_wptr+k)%MB] = 1'b1;
    end
    m_wptr = (m_wptr + 4) % MB;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    m_wptr = 0;
  endtask

  // Waits for load_ready, performs one handshake and lets the four byte
  // writes complete; the reference memory is updated to match.
  task automatic send_word(input logic [31:0] w, input logic last);
    int t;
    t = 0;
    while (!load_ready && t < 20) begin
      tick();
      t++;
    end
    n_checks++;
    if (load_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL send_word_ready: load_ready=%0b required 1 after %0d cycles", load_ready, t);
    end
    load_valid = 1'b1;
    load_word  = w;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    repeat (4) tick();
    m_put_word(w);
  endtask

  task automatic test_reset();
    load_start = 1'b1;
    load_valid = 1'b1;
    load_word  = 32'hDEADBEEF;
    repeat (2) tick();
    n_checks++;
    if ({load_ready, busy, load_done, overflow} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_flags: ready/busy/done/ovf=%b required 0000",
               {load_ready, busy, load_done, overflow});
    end
    n_checks++;
    if (load_count !== '0) begin
      n_errors++;
      $display("FAIL reset_count: load_count=%0d required 0", load_count);
    end
    reset      = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_override_start: busy=%0b required 0", busy);
    end
  endtask

  task automatic test_single_word();
    int cyc;
    do_start();
    n_checks++;
    if ({busy, load_ready} !== 2'b11) begin
      n_errors++;
      $display("FAIL single_start: busy/ready=%b required 11", {busy, load_ready});
    end
    load_valid = 1'b1;
    load_word  = 32'h00300293;
    load_last  = 1'b1;
    tick();
    cyc = 1;
    load_valid = 1'b0;
    load_last  = 1'b0;
    n_checks++;
    if (load_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL single_ready_drop: load_ready=%0b required 0", load_ready);
    end
    while (!load_done && cyc < 20) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc !== 5 || load_done !== 1'b1) begin
      n_errors++;
      $display("FAIL single_latency: done=%0b after %0d cycles required 1 after 5", load_done, cyc);
    end
    m_put_word(32'h00300293);
    n_checks++;
    if (load_count !== CW'(1) || overflow !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL single_status: count=%0d ovf=%0b busy=%0b required 1 0 0",
               load_count, overflow, busy);
    end
    inst_addr = 64'd0;
    #1;
    n_checks++;
    if (instruction !== 32'h00300293) begin
      n_errors++;
      $display("FAIL single_fetch: Instruction=%h required 00300293", instruction);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3];
    int pulse_cyc [$];
    int idx, cyc;
    logic r;
    w[0] = 32'h00502223;
    w[1] = 32'h00200293;
    w[2] = 32'h00503623;
    do_start();
    idx = 0;
    cyc = 0;
    load_valid = 1'b1;
    load_word  = w[0];
    load_last  = 1'b0;
    while (!load_done && cyc < 60) begin
      r = load_ready;
      if (r) pulse_cyc.push_back(cyc);
      tick();
      cyc++;
      if (r) begin
        idx++;
        if (idx < 3) begin
          load_word = w[idx];
          load_last = (idx == 2);
        end else begin
          load_valid = 1'b0;
          load_last  = 1'b0;
        end
      end
    end
    load_valid = 1'b0;
    n_checks++;
    if (pulse_cyc.size() !== 3) begin
      n_errors++;
      $display("FAIL b2b_pulses: load_ready pulses=%0d required 3", pulse_cyc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_checks++;
        if (pulse_cyc[i] - pulse_cyc[i-1] !== 5) begin
          n_errors++;
          $display("FAIL b2b_spacing: gap %0d=%0d cycles required 5", i, pulse_cyc[i] - pulse_cyc[i-1]);
        end
      end
    end
    for (int i = 0; i < 3; i++) m_put_word(w[i]);
    n_checks++;
    if (load_count !== CW'(3) || load_done !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_status: count=%0d done=%0b required 3 1", load_count, load_done);
    end
    for (int i = 0; i < 3; i++) begin
      inst_addr = 64'(4 * i);
      #1;
      n_checks++;
      if (instruction !== w[i]) begin
        n_errors++;
        $display("FAIL b2b_fetch: addr %0d Instruction=%h required %h", 4 * i, instruction, w[i]);
      end
    end
  endtask

  task automatic test_overflow();
    do_start();
    for (int i = 0; i < 4; i++) send_word($urandom, 1'b0);
    n_checks++;
    if ({load_done, overflow, busy} !== 3'b110 || load_count !== CW'(4)) begin
      n_errors++;
      $display("FAIL ovf_status: done/ovf/busy=%b count=%0d required 110 4",
               {load_done, overflow, busy}, load_count);
    end
    load_valid = 1'b1;
    load_word  = $urandom;
    load_last  = 1'b1;
    repeat (6) tick();
    n_checks++;
    if (load_ready !== 1'b0 || busy !== 1'b0 || load_count !== CW'(4)) begin
      n_errors++;
      $display("FAIL ovf_valid_ignored: ready=%0b busy=%0b count=%0d required 0 0 4",
               load_ready, busy, load_count);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    for (int a = 0; a < MB; a += 4) begin
      inst_addr = 64'(a);
      #1;
      n_checks++;
      if (instruction !== m_fetch(64'(a))) begin
        n_errors++;
        $display("FAIL ovf_mem_kept: addr %0d Instruction=%h required %h", a, instruction, m_fetch(64'(a)));
      end
    end
  endtask

  task automatic test_wrap_fetch();
    logic [31:0] exp;
    logic [63:0] a;
    exp = {m_mem[1], m_mem[0], m_mem[15], m_mem[14]};
    inst_addr = 64'd14;
    #1;
    n_checks++;
    if (instruction !== exp) begin
      n_errors++;
      $display("FAIL wrap_14: Instruction=%h required %h", instruction, exp);
    end
    exp = {m_mem[3], m_mem[2], m_mem[1], m_mem[0]};
    inst_addr = 64'h100;
    #1;
    n_checks++;
    if (instruction !== exp) begin
      n_errors++;
      $display("FAIL wrap_100: Instruction=%h required %h", instruction, exp);
    end
    for (int i = 0; i < 10; i++) begin
      a = {$urandom, $urandom};
      inst_addr = a;
      #1;
      n_checks++;
      if (instruction !== m_fetch(a)) begin
        n_errors++;
        $display("FAIL wrap_random: addr %h Instruction=%h required %h", a, instruction, m_fetch(a));
      end
    end
  endtask

  task automatic test_restart();
    logic [31:0] wa, wb, wc;
    wa = $urandom;
    wb = $urandom;
    wc = $urandom;
    do_start();
    for (int i = 0; i < 3; i++) begin
      inst_addr = {$urandom, $urandom};
      #1;
      n_checks++;
      if (instruction !== NOP) begin
        n_errors++;
        $display("FAIL busy_nop: addr %h Instruction=%h required %h", inst_addr, instruction, NOP);
      end
    end
    load_valid = 1'b1;
    load_word  = wa;
    load_last  = 1'b0;
    tick();
    load_valid = 1'b0;
    tick();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    repeat (2) tick();
    m_put_word(wa);
    send_word(wb, 1'b1);
    n_checks++;
    if (load_count !== CW'(2) || load_done !== 1'b1) begin
      n_errors++;
      $display("FAIL restart_ignored: count=%0d done=%0b required 2 1", load_count, load_done);
    end
    inst_addr = 64'd4;
    #1;
    n_checks++;
    if (instruction !== wb) begin
      n_errors++;
      $display("FAIL restart_ignored_fetch: addr 4 Instruction=%h required %h", instruction, wb);
    end
    do_start();
    n_checks++;
    if ({load_done, busy, overflow} !== 3'b010 || load_count !== '0) begin
      n_errors++;
      $display("FAIL restart_done: done/busy/ovf=%b count=%0d required 010 0",
               {load_done, busy, overflow}, load_count);
    end
    send_word(wc, 1'b1);
    inst_addr = 64'd0;
    #1;
    n_checks++;
    if (instruction !== wc) begin
      n_errors++;
      $display("FAIL restart_fetch0: Instruction=%h required %h", instruction, wc);
    end
  endtask

  task automatic test_reset_midload();
    logic [31:0] w1, w2, exp;
    w1 = $urandom;
    w2 = $urandom | 32'h00008080;
    do_start();
    send_word(w1, 1'b0);
    load_valid = 1'b1;
    load_word  = w2;
    tick();
    load_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_mem[4] = w2[7:0];
    m_mem[5] = w2[15:8];
    n_checks++;
    if ({busy, load_ready, load_done} !== 3'b000 || load_count !== '0) begin
      n_errors++;
      $display("FAIL midreset_status: busy/ready/done=%b count=%0d required 000 0",
               {busy, load_ready, load_done}, load_count);
    end
    exp = m_fetch(64'd4);
    inst_addr = 64'd4;
    #1;
    n_checks++;
    if (instruction !== exp || instruction === NOP) begin
      n_errors++;
      $display("FAIL midreset_bytes: Instruction=%h required %h", instruction, exp);
    end
    load_valid = 1'b1;
    load_word  = $urandom;
    repeat (4) tick();
    load_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || instruction !== exp) begin
      n_errors++;
      $display("FAIL idle_valid_ignored: busy=%0b Instruction=%h required 0 %h", busy, instruction, exp);
    end
  endtask

  task automatic test_random_loads();
    int n, nw;
    logic [63:0] a;
    for (int it = 0; it < 6; it++) begin
      n  = $urandom_range(1, 5);
      nw = (n > 4) ? 4 : n;
      do_start();
      for (int i = 0; i < nw; i++) send_word($urandom, (i == n - 1));
      n_checks++;
      if (load_count !== CW'(nw) || load_done !== 1'b1 || overflow !== (n == 5)) begin
        n_errors++;
        $display("FAIL random_status: iter %0d count=%0d done=%0b ovf=%0b required %0d 1 %0b",
                 it, load_count, load_done, overflow, nw, (n == 5));
      end
      for (int j = 0; j < 4; j++) begin
        a = {$urandom, $urandom};
        inst_addr = a;
        #1;
        if (m_fetch_known(a)) begin
          n_checks++;
          if (instruction !== m_fetch(a)) begin
            n_errors++;
            $display("FAIL random_fetch: addr %h Instruction=%h required %h", a, instruction, m_fetch(a));
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < MB; i++) begin
      m_mem[i]   = 8'h00;
      m_known[i] = 1'b0;
    end
    test_reset();
    test_single_word();
    test_back_to_back();
    test_overflow();
    test_wrap_fetch();
    test_restart();
    test_reset_midload();
    test_random_loads();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
